red_pitaya_asg_seq: RTL
=======================

// Module: red_pitaya_asg_seq
// PURPOSE
// Segment sequencer for one ASG channel. Holds a small table of waveform segments
// (buffer offset, size, step, repetition count, successor) and steps the channel through them:
// per segment it loads the config, resets the channel FSM and fires a software trigger.
// It then counts wrap events, and advances to the next segment or ends/loops the sequence.
// It sits between the bus register bank and the channel's set_*/trig_sw inputs.
// PARAMETERS
// RSZ    14  buffer address width; channel pointer width is RSZ+16 (16 fractional bits)
// IDX_W   3  segment index width; table depth 2**IDX_W
// BLANK   3  RUN cycles after trigger during which trig_done_i is ignored
// PORTS
// dac_clk_i     in   1        dac clock, sole clock
// dac_rstn_i    in   1        reset, synchronous, active-low
// tbl_we_i      in   1        table write strobe
// tbl_addr_i    in   IDX_W    entry to write
// tbl_fld_i     in   2        field: 0 ofs, 1 size, 2 step, 3 {last[31],next[16+IDX_W-1:16],reps[15:0]}
// tbl_wdata_i   in   32       write data (ofs/size/step use [RSZ+15:0])
// start_i       in   1        start pulse (honoured only in IDLE)
// stop_i        in   1        abort pulse (any state)
// loop_i        in   1        on last entry: 1 restart at start_idx_i, 0 finish
// start_idx_i   in   IDX_W    first entry of the sequence
// trig_done_i   in   1        channel trig_done_o (wrap events)
// set_ofs_o     out  RSZ+16   to channel set_ofs_i
// set_size_o    out  RSZ+16   to channel set_size_i
// set_step_o    out  RSZ+16   to channel set_step_i
// set_ncyc_o    out  32       constant 0 (channel runs until reset)
// set_rst_o     out  1        to channel set_rst_i
// trig_sw_o     out  1        to channel trig_sw_i (channel trig_src tied to 3'd1 by integration)
// busy_o        out  1        FSM not in IDLE
// seg_idx_o     out  IDX_W    entry currently played
// seq_done_o    out  1        one-cycle pulse when a non-looping sequence ends
// BEHAVIOUR
// - Reset: all outputs 0, state IDLE, seg index 0, rep count 0. Table contents NOT reset (write before start).
// - All outputs registered. States: IDLE, LOAD, ARM, FIRE, RUN, NEXT, DONE.
// - IDLE: start_i & !stop_i -> LOAD with idx<=start_idx_i.
// - LOAD (1 cyc): latch table[idx] into set_ofs/size/step, seg_idx_o<=idx, rep_cnt<=0 -> ARM.
// - ARM (1 cyc): set_rst_o=1 -> FIRE. FIRE (1 cyc): trig_sw_o=1 -> RUN, blank_cnt<=BLANK.
// - Start latency: start_i at t -> set_rst_o high at t+2, trig_sw_o high at t+3.
// - RUN: trig_done_i ignored while blank_cnt!=0 (decrements each cycle). Qualified trig_done_i:
//   if rep_cnt+1 >= max(reps,1) -> NEXT, else rep_cnt++. reps=0 behaves as 1. rep_cnt is 16 bits, no wrap.
// - NEXT (1 cyc): !last -> idx<=next, LOAD; last & loop_i -> idx<=start_idx_i, LOAD; last & !loop_i -> DONE.
// - Segment switch gap: NEXT, LOAD, ARM, FIRE = 4 cycles between last wrap and new trigger.
// - DONE (1 cyc): set_rst_o=1, seq_done_o=1 -> IDLE. Config outputs hold last values.
// - stop_i in any non-IDLE state: next cycle state IDLE, set_rst_o=1 for that one cycle,
//   trig_sw_o=0, no seq_done_o. stop_i wins over simultaneous start_i or trig_done_i.
// - stop_i in IDLE: no effect. start_i while busy: ignored.
// - Table writes always accepted. A write to the playing entry takes effect at its next LOAD only.
// - next pointing at self is legal (segment repeats until stop or loop).
// - loop_i is sampled in NEXT only.
// STRUCTURE
// - Include file asg_seq_defs.vh: state encodings, tbl_fld codes, field bit positions of word 3.
// - Sub-module red_pitaya_asg_seq_tbl: 2**IDX_W x 4-field register file, one write port, comb read by idx.
// - Top: FSM, rep/blank counters, output registers.
// TESTING
// - Reset with garbage on inputs -> all outputs 0, busy_o=0 until start.
// - Entry0 {ofs=0,size=0x10000<<4,step=0x10000,reps=2,last=1}, loop_i=0, start at t -> rst@t+2,
//   trig@t+3; 2 qualified trig_done_i -> seq_done_o pulse 2 cycles after the 2nd, busy_o=0.
// - Chain 0->3->1(last), loop_i=1 -> seg_idx_o 0,3,1,0,3..., 4-cycle gap between segments.
// - trig_done_i pulse 1 cycle after trig_sw_o -> ignored (rep_cnt stays 0); same pulse at blank end -> counted.
// - stop_i coincident with qualifying trig_done_i in RUN -> IDLE, single set_rst_o pulse, no seq_done_o.
// - Rewrite step of playing entry mid-RUN -> set_step_o unchanged until that entry reloads; reps=0 -> 1 wrap.

Source files
------------

// File: rtl/red_pitaya_asg_seq_pkg.sv
// Shared definitions for the ASG segment sequencer.
// Contents:
//   seq_state_e  sequencer FSM states
//   tbl_fld_e    table field select codes used on tbl_fld_i
//   Ctrl*        bit positions inside the control word (field 3)
//   eff_reps()   repetition count with 0 treated as 1
package red_pitaya_asg_seq_pkg;

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StLoad = 3'd1,
    StArm  = 3'd2,
    StFire = 3'd3,
    StRun  = 3'd4,
    StNext = 3'd5,
    StDone = 3'd6
  } seq_state_e;

  typedef enum logic [1:0] {
    FldOfs  = 2'd0,
    FldSize = 2'd1,
    FldStep = 2'd2,
    FldCtrl = 2'd3
  } tbl_fld_e;

  // Control word layout: {last[31], next[CtrlNextLsb +: IDX_W], reps[CtrlRepsW-1:0]}
  localparam int unsigned CtrlLastBit = 31;
  localparam int unsigned CtrlNextLsb = 16;
  localparam int unsigned CtrlRepsW   = 16;

  // A segment always plays at least one wrap.
  function automatic logic [CtrlRepsW-1:0] eff_reps(input logic [CtrlRepsW-1:0] reps);
    return (reps == '0) ? CtrlRepsW'(1) : reps;
  endfunction

endpackage

// File: rtl/red_pitaya_asg_seq_tbl.sv
// Segment table: 2**IDX_W entries of {ofs, size, step, last, next, reps}.
// One synchronous write port selecting a single field, one combinational read port.
// Contents are not reset.
// Ports:
//   clk                       clock
//   we, waddr, fld, wdata     field write (fld: 0 ofs, 1 size, 2 step, 3 control word)
//   raddr                     read index
//   rd_ofs/rd_size/rd_step    pointer fields of entry raddr (RSZ+16 bits)
//   rd_reps/rd_next/rd_last   control fields of entry raddr
module red_pitaya_asg_seq_tbl
  import red_pitaya_asg_seq_pkg::*;
#(
  parameter int unsigned RSZ   = 14,
  parameter int unsigned IDX_W = 3
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [IDX_W-1:0]     waddr,
  input  logic [1:0]           fld,
  input  logic [31:0]          wdata,
  input  logic [IDX_W-1:0]     raddr,
  output logic [RSZ+15:0]      rd_ofs,
  output logic [RSZ+15:0]      rd_size,
  output logic [RSZ+15:0]      rd_step,
  output logic [CtrlRepsW-1:0] rd_reps,
  output logic [IDX_W-1:0]     rd_next,
  output logic                 rd_last
);

  localparam int unsigned Depth = 2 ** IDX_W;
  localparam int unsigned PW    = RSZ + 16;

  logic [PW-1:0]        ofs_mem  [Depth];
  logic [PW-1:0]        size_mem [Depth];
  logic [PW-1:0]        step_mem [Depth];
  logic [CtrlRepsW-1:0] reps_mem [Depth];
  logic [IDX_W-1:0]     next_mem [Depth];
  logic                 last_mem [Depth];

  always_ff @(posedge clk) begin
    if (we) begin
      unique case (tbl_fld_e'(fld))
        FldOfs:  ofs_mem[waddr]  <= wdata[PW-1:0];
        FldSize: size_mem[waddr] <= wdata[PW-1:0];
        FldStep: step_mem[waddr] <= wdata[PW-1:0];
        FldCtrl: begin
          reps_mem[waddr] <= wdata[CtrlRepsW-1:0];
          next_mem[waddr] <= wdata[CtrlNextLsb +: IDX_W];
          last_mem[waddr] <= wdata[CtrlLastBit];
        end
        default: ;
      endcase
    end
  end

  assign rd_ofs  = ofs_mem[raddr];
  assign rd_size = size_mem[raddr];
  assign rd_step = step_mem[raddr];
  assign rd_reps = reps_mem[raddr];
  assign rd_next = next_mem[raddr];
  assign rd_last = last_mem[raddr];

  // Not every write-data bit maps to a field for all parameterisations.
  logic unused_wdata;
  assign unused_wdata = ^wdata;

endmodule

// File: rtl/red_pitaya_asg_seq.sv
// Segment sequencer for one ASG channel.
// Steps the channel through a table of waveform segments: per segment it latches the
// entry config, pulses the channel reset, fires a software trigger, then counts wrap
// events (trig_done_i) and moves to the successor entry, loops, or finishes.
// Ports:
//   dac_clk_i, dac_rstn_i            clock, synchronous active-low reset
//   tbl_we_i/addr_i/fld_i/wdata_i    segment table write port
//   start_i, stop_i, loop_i          sequence control; start_idx_i first entry
//   trig_done_i                      channel wrap event
//   set_ofs_o/size_o/step_o/ncyc_o   channel config
//   set_rst_o, trig_sw_o             channel reset and software trigger
//   busy_o, seg_idx_o, seq_done_o    status
module red_pitaya_asg_seq
  import red_pitaya_asg_seq_pkg::*;
#(
  parameter int unsigned RSZ   = 14,
  parameter int unsigned IDX_W = 3,
  parameter int unsigned BLANK = 3
) (
  input  logic             dac_clk_i,
  input  logic             dac_rstn_i,
  input  logic             tbl_we_i,
  input  logic [IDX_W-1:0] tbl_addr_i,
  input  logic [1:0]       tbl_fld_i,
  input  logic [31:0]      tbl_wdata_i,
  input  logic             start_i,
  input  logic             stop_i,
  input  logic             loop_i,
  input  logic [IDX_W-1:0] start_idx_i,
  input  logic             trig_done_i,
  output logic [RSZ+15:0]  set_ofs_o,
  output logic [RSZ+15:0]  set_size_o,
  output logic [RSZ+15:0]  set_step_o,
  output logic [31:0]      set_ncyc_o,
  output logic             set_rst_o,
  output logic             trig_sw_o,
  output logic             busy_o,
  output logic [IDX_W-1:0] seg_idx_o,
  output logic             seq_done_o
);

  localparam int unsigned PW     = RSZ + 16;
  localparam int unsigned BlankW = (BLANK < 1) ? 1 : $clog2(BLANK + 1);

  seq_state_e           state_q;
  logic [IDX_W-1:0]     idx_q;
  logic [CtrlRepsW-1:0] rep_cnt_q;
  logic [BlankW-1:0]    blank_cnt_q;

  // Control fields latched at LOAD so table writes only affect the next load.
  logic [CtrlRepsW-1:0] reps_q;
  logic [IDX_W-1:0]     next_q;
  logic                 last_q;

  logic [PW-1:0]        tbl_ofs;
  logic [PW-1:0]        tbl_size;
  logic [PW-1:0]        tbl_step;
  logic [CtrlRepsW-1:0] tbl_reps;
  logic [IDX_W-1:0]     tbl_next;
  logic                 tbl_last;

  red_pitaya_asg_seq_tbl #(
    .RSZ   (RSZ),
    .IDX_W (IDX_W)
  ) u_tbl (
    .clk     (dac_clk_i),
    .we      (tbl_we_i),
    .waddr   (tbl_addr_i),
    .fld     (tbl_fld_i),
    .wdata   (tbl_wdata_i),
    .raddr   (idx_q),
    .rd_ofs  (tbl_ofs),
    .rd_size (tbl_size),
    .rd_step (tbl_step),
    .rd_reps (tbl_reps),
    .rd_next (tbl_next),
    .rd_last (tbl_last)
  );

  // Widened by one bit so a counter at its maximum cannot wrap in the compare.
  logic [CtrlRepsW:0] rep_inc;
  logic               reps_reached;

  assign rep_inc      = {1'b0, rep_cnt_q} + (CtrlRepsW + 1)'(1);
  assign reps_reached = rep_inc >= {1'b0, eff_reps(reps_q)};

  // Channel runs until the sequencer resets it.
  assign set_ncyc_o = '0;

  always_ff @(posedge dac_clk_i) begin
    if (!dac_rstn_i) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      rep_cnt_q   <= '0;
      blank_cnt_q <= '0;
      reps_q      <= '0;
      next_q      <= '0;
      last_q      <= 1'b0;
      set_ofs_o   <= '0;
      set_size_o  <= '0;
      set_step_o  <= '0;
      set_rst_o   <= 1'b0;
      trig_sw_o   <= 1'b0;
      busy_o      <= 1'b0;
      seg_idx_o   <= '0;
      seq_done_o  <= 1'b0;
    end else begin
      set_rst_o  <= 1'b0;
      trig_sw_o  <= 1'b0;
      seq_done_o <= 1'b0;

      if (stop_i && (state_q != StIdle)) begin
        // Abort outranks every other event; leave the channel held in reset for one cycle.
        state_q   <= StIdle;
        busy_o    <= 1'b0;
        set_rst_o <= 1'b1;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (start_i && !stop_i) begin
              state_q <= StLoad;
              idx_q   <= start_idx_i;
              busy_o  <= 1'b1;
            end
          end
          StLoad: begin
            set_ofs_o  <= tbl_ofs;
            set_size_o <= tbl_size;
            set_step_o <= tbl_step;
            reps_q     <= tbl_reps;
            next_q     <= tbl_next;
            last_q     <= tbl_last;
            seg_idx_o  <= idx_q;
            rep_cnt_q  <= '0;
            set_rst_o  <= 1'b1;
            state_q    <= StArm;
          end
          StArm: begin
            trig_sw_o <= 1'b1;
            state_q   <= StFire;
          end
          StFire: begin
            blank_cnt_q <= BlankW'(BLANK);
            state_q     <= StRun;
          end
          StRun: begin
            // Wrap events right after the trigger are stale and must not count.
            if (blank_cnt_q != '0) begin
              blank_cnt_q <= blank_cnt_q - BlankW'(1);
            end else if (trig_done_i) begin
              if (reps_reached) begin
                state_q <= StNext;
              end else begin
                rep_cnt_q <= rep_inc[CtrlRepsW-1:0];
              end
            end
          end
          StNext: begin
            if (!last_q) begin
              idx_q   <= next_q;
              state_q <= StLoad;
            end else if (loop_i) begin
              idx_q   <= start_idx_i;
              state_q <= StLoad;
            end else begin
              set_rst_o  <= 1'b1;
              seq_done_o <= 1'b1;
              state_q    <= StDone;
            end
          end
          StDone: begin
            busy_o  <= 1'b0;
            state_q <= StIdle;
          end
          default: begin
            busy_o  <= 1'b0;
            state_q <= StIdle;
          end
        endcase
      end
    end
  end

endmodule
